// File: rtl/lcd_block_frame_gen_if.sv
// Render-control and display read-port bundle for lcd_block_frame_gen.
// master: the controlling/consuming side; slave: the frame generator itself.
interface lcd_block_frame_gen_if;
  logic       start;
  logic [6:0] x0;
  logic [6:0] x1;
  logic [5:0] y0;
  logic [5:0] y1;
  logic       invert;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic       frame_valid;

  modport master (
    output start, x0, x1, y0, y1, invert, rd_addr,
    input  rd_data, busy, done, frame_valid
  );

  modport slave (
    input  start, x0, x1, y0, y1, invert, rd_addr,
    output rd_data, busy, done, frame_valid
  );
endinterface

// File: rtl/lcd_block_frame_gen.sv
// Renders one filled rectangle into a 1024-byte frame buffer laid out the way the
// 128x64 LCD controller walks it: addr[9:4] = pixel row, addr[3:0] = 8-pixel column.
// One byte is written per clock while busy; the read port is always live.
module lcd_block_frame_gen #(
  parameter bit MSB_LEFT = 1'b1  // 1: bit 7 is the leftmost pixel of a byte
) (
  input logic             clk,
  input logic             rst,
  lcd_block_frame_gen_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  localparam logic [9:0] LastAddr = 10'd1023;

  state_e     state_q;
  logic [9:0] wr_cnt_q;
  logic [6:0] x0_q;
  logic [6:0] x1_q;
  logic [5:0] y0_q;
  logic [5:0] y1_q;
  logic       invert_q;
  logic       busy_q;
  logic       done_q;
  logic       frame_valid_q;
  logic [7:0] rd_data_q;

  // Frame buffer has no reset: contents are undefined until the first frame completes.
  logic [7:0] mem [1024];

  logic [5:0] row;
  logic       row_hit;
  logic [7:0] wr_byte;

  assign row     = wr_cnt_q[9:4];
  assign row_hit = (row >= y0_q) && (row <= y1_q);

  // Eight parallel column compares; an inverted range (x0>x1 / y0>y1) never hits.
  for (genvar p = 0; p < 8; p++) begin : g_pix
    localparam int unsigned BitIdx = MSB_LEFT ? (7 - p) : p;
    logic [6:0] px;
    assign px              = {wr_cnt_q[3:0], 3'(p)};
    assign wr_byte[BitIdx] = ((px >= x0_q) && (px <= x1_q) && row_hit) ^ invert_q;
  end

  // Render FSM: latch request in idle, sweep all 1024 bytes, then flag completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      wr_cnt_q      <= '0;
      x0_q          <= '0;
      x1_q          <= '0;
      y0_q          <= '0;
      y1_q          <= '0;
      invert_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            x0_q          <= bus.x0;
            x1_q          <= bus.x1;
            y0_q          <= bus.y0;
            y1_q          <= bus.y1;
            invert_q      <= bus.invert;
            wr_cnt_q      <= '0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= StFill;
          end
        end
        StFill: begin
          // Counter holds at the last address rather than wrapping.
          if (wr_cnt_q == LastAddr) begin
            state_q <= StDone;
          end else begin
            wr_cnt_q <= wr_cnt_q + 10'd1;
          end
        end
        StDone: begin
          busy_q        <= 1'b0;
          done_q        <= 1'b1;
          frame_valid_q <= 1'b1;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Buffer write, one byte per fill cycle.
  always_ff @(posedge clk) begin
    if (state_q == StFill) begin
      mem[wr_cnt_q] <= wr_byte;
    end
  end

  // Registered read; a same-cycle write to the same address is seen on the next read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[bus.rd_addr];
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_lcd_block_frame_gen.sv
// Self-checking bench: two generators (MSB_LEFT=1 and 0) share stimulus; expected read
// bytes are pushed to scoreboard queues when the read is issued and popped on output.
module tb_lcd_block_frame_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  lcd_block_frame_gen_if bus_m ();
  lcd_block_frame_gen_if bus_l ();

  assign bus_l.start   = bus_m.start;
  assign bus_l.x0      = bus_m.x0;
  assign bus_l.x1      = bus_m.x1;
  assign bus_l.y0      = bus_m.y0;
  assign bus_l.y1      = bus_m.y1;
  assign bus_l.invert  = bus_m.invert;
  assign bus_l.rd_addr = bus_m.rd_addr;

  lcd_block_frame_gen #(.MSB_LEFT(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
  lcd_block_frame_gen #(.MSB_LEFT(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  int errors = 0;
  int checks = 0;

  logic [7:0] model_m [1024];
  logic [7:0] model_l [1024];
  logic [7:0] exp_m [$];
  logic [7:0] exp_l [$];

  // Reference pixel model: walk pixels left to right, place each per bit order.
  function automatic logic [7:0] model_byte(input logic [9:0] a, input int fx0, input int fx1,
                                            input int fy0, input int fy1, input bit inv,
                                            input bit msb);
    logic [7:0] b;
    int y;
    b = 8'h00;
    y = int'(a[9:4]);
    for (int p = 0; p < 8; p++) begin
      int x;
      bit on;
      x  = int'(a[3:0]) * 8 + p;
      on = ((x >= fx0) && (x <= fx1) && (y >= fy0) && (y <= fy1)) ^ inv;
      if (msb) b[7 - p] = on;
      else     b[p] = on;
    end
    return b;
  endfunction

  task automatic update_model(input int fx0, input int fx1, input int fy0, input int fy1,
                              input bit inv);
    for (int a = 0; a < 1024; a++) begin
      model_m[a] = model_byte(10'(a), fx0, fx1, fy0, fy1, inv, 1'b1);
      model_l[a] = model_byte(10'(a), fx0, fx1, fy0, fy1, inv, 1'b0);
    end
  endtask

  // Leaves the bench #1 after the edge that sampled start (edge T).
  task automatic pulse_start(input int fx0, input int fx1, input int fy0, input int fy1,
                             input bit inv);
    @(negedge clk);
    bus_m.x0     = 7'(fx0);
    bus_m.x1     = 7'(fx1);
    bus_m.y0     = 6'(fy0);
    bus_m.y1     = 6'(fy1);
    bus_m.invert = inv;
    bus_m.start  = 1'b1;
    @(posedge clk);
    #1;
    bus_m.start = 1'b0;
  endtask

  // Waits (bounded) for done; done_at is cycles after T, or -1 on timeout.
  task automatic wait_done(output int busy_cnt, output int done_at);
    busy_cnt = 0;
    done_at  = -1;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk);
      #1;
      if (bus_m.busy === 1'b1) busy_cnt++;
      if (bus_m.done === 1'b1) begin
        done_at = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus_m.start   = 1'b0;
    bus_m.x0      = '0;
    bus_m.x1      = '0;
    bus_m.y0      = '0;
    bus_m.y1      = '0;
    bus_m.invert  = 1'b0;
    bus_m.rd_addr = '0;
    rst = 1'b0;
    #35;
    checks++; if (bus_m.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus_m.busy); end
    checks++; if (bus_m.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus_m.done); end
    checks++; if (bus_m.frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b want=0", bus_m.frame_valid); end
    checks++; if (bus_m.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data_m got=%h want=00", bus_m.rd_data); end
    checks++; if (bus_l.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data_l got=%h want=00", bus_l.rd_data); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus_m.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b want=0", bus_m.busy); end
  endtask

  task automatic test_basic();
    logic [9:0] addrs [3] = '{10'h001, 10'h000, 10'h011};
    logic [7:0] vals  [3] = '{8'hFF, 8'h00, 8'h00};
    int bc, da;
    logic [7:0] e;
    pulse_start(8, 15, 0, 0, 1'b0);
    wait_done(bc, da);
    checks++; if (bc != 1024) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=1024", bc); end
    checks++; if (da != 1025) begin errors++; $display("FAIL basic_done_at got=%0d want=1025", da); end
    checks++; if (bus_m.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b want=0", bus_m.busy); end
    checks++; if (bus_m.frame_valid !== 1'b1) begin errors++; $display("FAIL basic_fv got=%b want=1", bus_m.frame_valid); end
    @(posedge clk);
    #1;
    checks++; if (bus_m.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b want=0", bus_m.done); end
    update_model(8, 15, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_m.push_back(vals[i]);
      @(negedge clk);
      bus_m.rd_addr = addrs[i];
      @(posedge clk);
      #1;
      e = exp_m.pop_front();
      checks++;
      if (bus_m.rd_data !== e) begin
        errors++; $display("FAIL basic_read addr=%h got=%h want=%h", addrs[i], bus_m.rd_data, e);
      end
    end
    for (int i = 0; i < 8; i++) begin
      logic [9:0] a;
      a = 10'($urandom_range(0, 1023));
      exp_m.push_back(model_m[a]);
      exp_l.push_back(model_l[a]);
      @(negedge clk);
      bus_m.rd_addr = a;
      @(posedge clk);
      #1;
      e = exp_m.pop_front();
      checks++;
      if (bus_m.rd_data !== e) begin
        errors++; $display("FAIL basic_rand_m addr=%h got=%h want=%h", a, bus_m.rd_data, e);
      end
      e = exp_l.pop_front();
      checks++;
      if (bus_l.rd_data !== e) begin
        errors++; $display("FAIL basic_rand_l addr=%h got=%h want=%h", a, bus_l.rd_data, e);
      end
    end
  endtask

  task automatic test_partial();
    logic [9:0] addrs [3] = '{10'h050, 10'h051, 10'h052};
    logic [7:0] vm    [3] = '{8'h1F, 8'hC0, 8'h00};
    logic [7:0] vl    [3] = '{8'hF8, 8'h03, 8'h00};
    int bc, da;
    logic [7:0] e;
    pulse_start(3, 9, 5, 5, 1'b0);
    wait_done(bc, da);
    checks++; if (da != 1025) begin errors++; $display("FAIL partial_done_at got=%0d want=1025", da); end
    update_model(3, 9, 5, 5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_m.push_back(vm[i]);
      exp_l.push_back(vl[i]);
      @(negedge clk);
      bus_m.rd_addr = addrs[i];
      @(posedge clk);
      #1;
      e = exp_m.pop_front();
      checks++;
      if (bus_m.rd_data !== e) begin
        errors++; $display("FAIL partial_msb addr=%h got=%h want=%h", addrs[i], bus_m.rd_data, e);
      end
      e = exp_l.pop_front();
      checks++;
      if (bus_l.rd_data !== e) begin
        errors++; $display("FAIL partial_lsb addr=%h got=%h want=%h", addrs[i], bus_l.rd_data, e);
      end
    end
  endtask

  task automatic test_full_row();
    int bc, da;
    logic [7:0] e;
    logic [9:0] a;
    pulse_start(0, 127, 40, 40, 1'b0);
    wait_done(bc, da);
    checks++; if (da != 1025) begin errors++; $display("FAIL row_done_at got=%0d want=1025", da); end
    update_model(0, 127, 40, 40, 1'b0);
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        a = 10'h280 + 10'(i);
        exp_m.push_back(8'hFF);
      end else begin
        a = (i == 16) ? 10'h080 : 10'h270;
        exp_m.push_back(8'h00);
      end
      @(negedge clk);
      bus_m.rd_addr = a;
      @(posedge clk);
      #1;
      e = exp_m.pop_front();
      checks++;
      if (bus_m.rd_data !== e || bus_l.rd_data !== e) begin
        errors++;
        $display("FAIL row_read addr=%h got_m=%h got_l=%h want=%h", a, bus_m.rd_data,
                 bus_l.rd_data, e);
      end
    end
  endtask

  task automatic test_empty_ignore();
    int done_cnt;
    logic [7:0] e;
    done_cnt = 0;
    pulse_start(20, 10, 0, 63, 1'b1);
    for (int k = 1; k <= 2200; k++) begin
      @(posedge clk);
      #1;
      if (bus_m.done === 1'b1) done_cnt++;
      // Mid-fill restart with new coordinates, then one coinciding with the done cycle.
      if (k == 500 || k == 1024) begin
        bus_m.x0 = 7'd0; bus_m.x1 = 7'd127; bus_m.invert = 1'b0; bus_m.start = 1'b1;
      end
      if (k == 501 || k == 1025) bus_m.start = 1'b0;
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_count got=%0d want=1", done_cnt); end
    checks++; if (bus_m.busy !== 1'b0) begin errors++; $display("FAIL ignore_busy got=%b want=0", bus_m.busy); end
    update_model(20, 10, 0, 63, 1'b1);
    for (int a = 0; a < 1024; a++) begin
      exp_m.push_back(model_m[a]);
      @(negedge clk);
      bus_m.rd_addr = 10'(a);
      @(posedge clk);
      #1;
      e = exp_m.pop_front();
      checks++;
      if (bus_m.rd_data !== e) begin
        errors++; $display("FAIL empty_read addr=%h got=%h want=%h", a, bus_m.rd_data, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bc, da;
    pulse_start(0, 127, 0, 63, 1'b0);
    repeat (500) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus_m.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", bus_m.busy); end
    checks++; if (bus_m.done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b want=0", bus_m.done); end
    checks++; if (bus_m.frame_valid !== 1'b0) begin errors++; $display("FAIL midrst_fv got=%b want=0", bus_m.frame_valid); end
    checks++; if (bus_m.rd_data !== 8'h00) begin errors++; $display("FAIL midrst_rd_data got=%h want=00", bus_m.rd_data); end
    @(negedge clk);
    rst = 1'b1;
    pulse_start(0, 127, 0, 63, 1'b0);
    wait_done(bc, da);
    checks++; if (da != 1025) begin errors++; $display("FAIL midrst_restart_done_at got=%0d want=1025", da); end
    checks++; if (bus_m.frame_valid !== 1'b1) begin errors++; $display("FAIL midrst_restart_fv got=%b want=1", bus_m.frame_valid); end
    update_model(0, 127, 0, 63, 1'b0);
  endtask

  task automatic test_read_first();
    int bc, da;
    logic [7:0] e;
    exp_m.push_back(model_m[10'h123]);
    pulse_start(0, 127, 0, 63, 1'b1);
    repeat (291) @(posedge clk);
    @(negedge clk);
    bus_m.rd_addr = 10'h123;
    @(posedge clk);  // edge T+292 writes 0x123 and reads it
    #1;
    e = exp_m.pop_front();
    checks++; if (bus_m.rd_data !== e) begin errors++; $display("FAIL rfirst_old got=%h want=%h", bus_m.rd_data, e); end
    exp_m.push_back(model_byte(10'h123, 0, 127, 0, 63, 1'b1, 1'b1));
    @(posedge clk);
    #1;
    e = exp_m.pop_front();
    checks++; if (bus_m.rd_data !== e) begin errors++; $display("FAIL rfirst_new got=%h want=%h", bus_m.rd_data, e); end
    wait_done(bc, da);
    checks++; if (da < 0) begin errors++; $display("FAIL rfirst_done got=timeout want=done"); end
    update_model(0, 127, 0, 63, 1'b1);
  endtask

  task automatic test_back_to_back();
    int bc, da;
    logic [7:0] e;
    pulse_start(0, 7, 0, 0, 1'b0);
    wait_done(bc, da);
    checks++; if (da != 1025) begin errors++; $display("FAIL b2b_first_done_at got=%0d want=1025", da); end
    // Earliest accepted restart: sampled on the edge right after done.
    bus_m.x0 = 7'd0; bus_m.x1 = 7'd127; bus_m.y0 = 6'd63; bus_m.y1 = 6'd63;
    bus_m.start = 1'b1;
    @(posedge clk);
    #1;
    bus_m.start = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus_m.busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got=%b want=1", bus_m.busy); end
    wait_done(bc, da);
    checks++; if (da != 1024) begin errors++; $display("FAIL b2b_second_done_at got=%0d want=1024", da); end
    update_model(0, 127, 63, 63, 1'b0);
    exp_m.push_back(model_m[10'h3F5]);
    exp_l.push_back(model_l[10'h000]);
    @(negedge clk);
    bus_m.rd_addr = 10'h3F5;
    @(posedge clk);
    #1;
    e = exp_m.pop_front();
    checks++; if (bus_m.rd_data !== e) begin errors++; $display("FAIL b2b_read_last_row got=%h want=%h", bus_m.rd_data, e); end
    @(negedge clk);
    bus_m.rd_addr = 10'h000;
    @(posedge clk);
    #1;
    e = exp_l.pop_front();
    checks++; if (bus_l.rd_data !== e) begin errors++; $display("FAIL b2b_read_row0 got=%h want=%h", bus_l.rd_data, e); end
  endtask

  initial begin
    #4ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_full_row();
    test_empty_ignore();
    test_reset_mid();
    test_read_first();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
